// File: rtl/router_bus_rr_switch.sv
// Shared-bus round-robin packet switch: pops one packet at a time from terminal source FIFOs
// and routes it by header ID into per-terminal show-ahead output FIFOs. Optional: ROUTER_DROP_CNT_EN.
module router_bus_rr_switch #(
    parameter int              pckg_sz    = 32,
    parameter int              num_ntrfs  = 4,
    parameter int              fifo_depth = 16,
    parameter int              id_w       = 8,
    parameter logic [id_w-1:0] broadcast  = {id_w{1'b1}}
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ntrfs*pckg_sz-1:0]   data_out_i_in,
    input  logic [num_ntrfs-1:0]           pndng_i_in,
    output logic [num_ntrfs-1:0]           popin,
    input  logic [num_ntrfs-1:0]           pop,
    output logic [num_ntrfs-1:0]           pndng,
    output logic [num_ntrfs*pckg_sz-1:0]   data_out
`ifdef ROUTER_DROP_CNT_EN
    ,
    output logic [15:0]                    drop_cnt
`endif
);

    localparam int idx_w = (num_ntrfs > 1) ? $clog2(num_ntrfs) : 1;
    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = ptr_w + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [idx_w-1:0]       rr_ptr_reg;
    logic [idx_w-1:0]       grant_reg;
    logic [pckg_sz-1:0]     pkt_reg;
    logic [num_ntrfs-1:0]   popin_reg;

    logic [pckg_sz-1:0]     src_words [num_ntrfs];
    logic [idx_w-1:0]       pick;
    logic [idx_w-1:0]       pick_hi;
    logic [idx_w-1:0]       pick_lo;
    logic                   found_hi;
    logic [num_ntrfs-1:0]   pick_onehot;
    logic [id_w-1:0]        dst;
    logic                   dst_valid;
    logic [num_ntrfs-1:0]   tgt_mask;
    logic [num_ntrfs-1:0]   full;
    logic                   can_push;
    logic                   push_en;
    logic                   drop_now;

    genvar gi;

    for (gi = 0; gi < num_ntrfs; gi++) begin : g_src
        assign src_words[gi] = data_out_i_in[gi*pckg_sz +: pckg_sz];
    end

    // Round-robin: lowest requester at or above rr_ptr, otherwise wrap to the lowest overall.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int k = num_ntrfs - 1; k >= 0; k--) begin
            if (pndng_i_in[k]) begin
                pick_lo = idx_w'(k);
                if (k >= int'(rr_ptr_reg)) begin
                    pick_hi  = idx_w'(k);
                    found_hi = 1'b1;
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        pick_onehot = '0;
        for (int k = 0; k < num_ntrfs; k++) begin
            pick_onehot[k] = (idx_w'(k) == pick);
        end
    end

    // Unicast (including self-send) takes priority over the broadcast code.
    assign dst       = pkt_reg[pckg_sz-1 -: id_w];
    assign dst_valid = (int'(dst) < num_ntrfs);

    always_comb begin
        tgt_mask = '0;
        for (int k = 0; k < num_ntrfs; k++) begin
            if (dst_valid) begin
                tgt_mask[k] = (int'(dst) == k);
            end else if (dst == broadcast) begin
                tgt_mask[k] = (k != int'(grant_reg));
            end
        end
    end

    assign can_push = ((tgt_mask & full) == '0);
    assign push_en  = (state_reg == ROUTE) && (tgt_mask != '0) && can_push;
    assign drop_now = (state_reg == ROUTE) && (tgt_mask == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
            pkt_reg    <= '0;
            popin_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pndng_i_in != '0) begin
                        grant_reg <= pick;
                        popin_reg <= pick_onehot;
                        state_reg <= POP;
                    end
                end
                POP: begin
                    popin_reg  <= '0;
                    pkt_reg    <= src_words[grant_reg];
                    rr_ptr_reg <= (int'(grant_reg) == num_ntrfs - 1) ? '0 : grant_reg + 1'b1;
                    state_reg  <= ROUTE;
                end
                ROUTE: begin
                    if (drop_now || push_en) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    popin_reg <= '0;
                end
            endcase
        end
    end

    assign popin = popin_reg;

    // Output FIFOs: memory has no reset; emptiness is carried by the counters alone.
    for (gi = 0; gi < num_ntrfs; gi++) begin : g_ofifo
        logic [pckg_sz-1:0] mem [fifo_depth];
        logic [ptr_w-1:0]   wr_ptr_reg;
        logic [ptr_w-1:0]   rd_ptr_reg;
        logic [cnt_w-1:0]   count_reg;
        logic               do_push;
        logic               do_pop;

        assign do_push  = push_en && tgt_mask[gi];
        assign do_pop   = pop[gi] && (count_reg != '0);
        assign full[gi] = (count_reg == cnt_w'(fifo_depth));

        always_ff @(posedge clk) begin
            if (do_push) begin
                mem[wr_ptr_reg] <= pkt_reg;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end

        assign pndng[gi] = (count_reg != '0);
        assign data_out[gi*pckg_sz +: pckg_sz] = pndng[gi] ? mem[rd_ptr_reg] : '0;
    end

`ifdef ROUTER_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_reg <= '0;
        end else if (drop_now && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_router_bus_rr_switch.sv
// Scoreboard bench for router_bus_rr_switch: directed scenarios followed by random traffic,
// checked against queue-based source/destination models and a round-robin grant model.
`timescale 1ns/1ps
module tb_router_bus_rr_switch;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int D   = 16;
    localparam int IDW = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N*W-1:0] data_out_i_in = '0;
    logic [N-1:0]   pndng_i_in = '0;
    logic [N-1:0]   popin;
    logic [N-1:0]   pop = '0;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] data_out;
`ifdef ROUTER_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    router_bus_rr_switch #(
        .pckg_sz(W), .num_ntrfs(N), .fifo_depth(D), .id_w(IDW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_out_i_in(data_out_i_in),
        .pndng_i_in(pndng_i_in),
        .popin(popin),
        .pop(pop),
        .pndng(pndng),
        .data_out(data_out)
`ifdef ROUTER_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] src_q [N][$];
    logic [W-1:0] exp_q [N][$];
    int           checks = 0;
    int           errors = 0;
    int           rr_model = 0;
    int           grant_cnt = 0;
    int           grant_log [$];
    int           exp_drops = 0;
    logic [N-1:0] pend_prev = '0;
    logic [N-1:0] popin_seen = '0;
    logic [N-1:0] pop_rand_en = '0;
    int           rr_order [8] = '{2, 3, 0, 1, 2, 3, 0, 1};

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %08h required %08h", name, act, req);
        end
    endfunction

    function automatic int rr_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] targets(input logic [W-1:0] p, input int src);
        logic [IDW-1:0] d;
        logic [N-1:0]   m;
        d = p[W-1 -: IDW];
        m = '0;
        if (int'(d) < N) begin
            m[int'(d)] = 1'b1;
        end else if (d == 8'hFF) begin
            m = '1;
            m[src] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [W-1:0] mk(input logic [IDW-1:0] id);
        logic [W-IDW-1:0] body;
        body = (W-IDW)'($urandom);
        return {id, body};
    endfunction

    function automatic bit src_busy();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_busy();
        for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void drive_src();
        for (int i = 0; i < N; i++) begin
            pndng_i_in[i] = (src_q[i].size() != 0);
            data_out_i_in[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endfunction

    // One clock: retire the word the DUT captured, record where it must appear, set pops.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (popin_seen[i] && src_q[i].size() != 0) begin
                logic [N-1:0] m;
                m = targets(src_q[i][0], i);
                for (int t = 0; t < N; t++) if (m[t]) exp_q[t].push_back(src_q[i][0]);
                if (m == '0) exp_drops++;
                void'(src_q[i].pop_front());
            end
        end
        popin_seen = '0;
        for (int i = 0; i < N; i++) pop[i] = pop_rand_en[i] ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_src();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_src_empty(input string name, input int limit);
        int n;
        n = 0;
        while (src_busy() && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (src_busy()) begin
            errors++;
            $display("FAIL %s: sources still pending after %0d cycles, required empty", name, limit);
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        pop_rand_en = '1;
        while ((src_busy() || exp_busy() || pndng != '0) && n < limit) begin
            tick();
            n++;
        end
        pop_rand_en = '0;
        tick();
        checks++;
        if (exp_busy()) begin
            errors++;
            $display("FAIL %s: expected words still undelivered after %0d cycles", name, limit);
        end
        check({name, "_pndng"}, W'(pndng), '0);
    endtask

    // Monitor: grant order against the round-robin rule, popped heads against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (popin != '0) begin
                int g;
                int a;
                logic [N-1:0] m;
                g = rr_pick(pend_prev, rr_model);
                m = '0;
                if (g >= 0) m[g] = 1'b1;
                a = 0;
                for (int i = N - 1; i >= 0; i--) if (popin[i]) a = i;
                checks++;
                if (popin !== m) begin
                    errors++;
                    $display("FAIL grant: popin %b, required %b (pending %b, rr %0d)", popin, m, pend_prev, rr_model);
                end
                rr_model = (a + 1) % N;
                grant_log.push_back(a);
                grant_cnt++;
                popin_seen = popin;
            end
            for (int i = 0; i < N; i++) begin
                if (pop[i] && pndng[i]) begin
                    logic [W-1:0] e;
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out%0d: actual word %08h, required none", i, data_out[i*W +: W]);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("out%0d", i), data_out[i*W +: W], e);
                    end
                end
                if (!pndng[i]) check($sformatf("idle_out%0d", i), data_out[i*W +: W], '0);
            end
            pend_prev = pndng_i_in;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int g0;

        // Reset state
        ticks(3);
        check("rst_popin", W'(popin), '0);
        check("rst_pndng", W'(pndng), '0);
        for (int i = 0; i < N; i++) check($sformatf("rst_data%0d", i), data_out[i*W +: W], '0);
`ifdef ROUTER_DROP_CNT_EN
        check("rst_drop_cnt", W'(drop_cnt), '0);
`endif
        reset = 1'b1;

        // Unicast timing: source 0 to terminal 2
        tick();
        src_q[0].push_back(32'h0200ABCD);
        drive_src();
        tick();
        check("t1_popin_e1", W'(popin), 32'h1);
        check("t1_pndng_e1", W'(pndng), '0);
        tick();
        check("t1_popin_e2", W'(popin), '0);
        check("t1_pndng_e2", W'(pndng), '0);
        tick();
        check("t1_pndng_e3", W'(pndng), 32'h4);
        check("t1_data2", data_out[2*W +: W], 32'h0200ABCD);
        drain("t1_drain", 50);

        // Broadcast from source 1
        src_q[1].push_back(32'hFF000011);
        drive_src();
        tick();
        check("t2_popin", W'(popin), 32'h2);
        ticks(2);
        check("t2_pndng", W'(pndng), 32'hD);
        check("t2_data0", data_out[0*W +: W], 32'hFF000011);
        check("t2_data2", data_out[2*W +: W], 32'hFF000011);
        check("t2_data3", data_out[3*W +: W], 32'hFF000011);
        drain("t2_drain", 50);

        // Round-robin with every source pending
        b = grant_log.size();
        for (int i = 0; i < N; i++) begin
            src_q[i].push_back(mk(IDW'((i + 1) % N)));
            src_q[i].push_back(mk(IDW'((i + 2) % N)));
        end
        drive_src();
        pop_rand_en = '1;
        wait_src_empty("t3_wait", 100);
        checks++;
        if (grant_log.size() < b + 8) begin
            errors++;
            $display("FAIL t3_grants: actual %0d grants, required 8", grant_log.size() - b);
        end else begin
            for (int k = 0; k < 8; k++) check($sformatf("t3_order%0d", k), W'(grant_log[b + k]), W'(rr_order[k]));
        end
        drain("t3_drain", 100);

        // Backpressure: fill terminal 3, one more packet stalls in ROUTE
        for (int k = 0; k < D + 1; k++) src_q[0].push_back(mk(8'h03));
        drive_src();
        wait_src_empty("t4_fill", 120);
        ticks(6);
        g0 = grant_cnt;
        src_q[2].push_back(mk(8'h01));
        drive_src();
        ticks(10);
        check("t4_hold_grants", W'(grant_cnt), W'(g0));
        check("t4_hold_src2", W'(src_q[2].size()), 32'd1);
        check("t4_hold_pndng", W'(pndng), 32'h8);
        pop = 4'b1000;
        tick();
        check("t4_popin_pop", W'(popin), '0);
        tick();
        check("t4_popin_push", W'(popin), '0);
        tick();
        check("t4_popin_next", W'(popin), 32'h4);
        ticks(3);
        check("t4_pndng_after", W'(pndng), 32'hA);

        // Reset while stalled in ROUTE with terminal 3 full
        src_q[1].push_back(mk(8'h03));
        drive_src();
        ticks(8);
        reset = 1'b0;
        #1;
        check("t5_rst_pndng", W'(pndng), '0);
        check("t5_rst_popin", W'(popin), '0);
        check("t5_rst_data3", data_out[3*W +: W], '0);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        popin_seen = '0;
        pend_prev = '0;
        rr_model = 0;
        exp_drops = 0;
        drive_src();
        ticks(2);
        reset = 1'b1;
        src_q[1].push_back(mk(8'h00));
        src_q[3].push_back(mk(8'h02));
        drive_src();
        tick();
        check("t5_first_grant", W'(popin), 32'h2);
        drain("t5_drain", 60);

        // Invalid destination ID is popped and dropped
        g0 = grant_cnt;
        src_q[0].push_back(mk(8'h07));
        drive_src();
        wait_src_empty("t6_wait", 20);
        ticks(4);
        check("t6_grants", W'(grant_cnt), W'(g0 + 1));
        check("t6_pndng", W'(pndng), '0);
`ifdef ROUTER_DROP_CNT_EN
        check("t6_drop_cnt", W'(drop_cnt), 32'd1);
`endif

        // Random mixed traffic
        pop_rand_en = '1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int s;
                int r;
                logic [IDW-1:0] id;
                s = $urandom_range(0, N - 1);
                r = $urandom_range(0, 7);
                if (r < 4)      id = IDW'(r);
                else if (r < 6) id = 8'hFF;
                else if (r == 6) id = IDW'($urandom_range(4, 254));
                else            id = IDW'(s);
                if (src_q[s].size() < 4) src_q[s].push_back(mk(id));
                drive_src();
            end
            tick();
        end
        drain("t7_drain", 1000);
`ifdef ROUTER_DROP_CNT_EN
        check("t7_drop_cnt", W'(drop_cnt), W'(exp_drops));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
